// File: rtl/cic_agc_ctrl.sv
// Peak-window AGC for the CIC decimator gain with decrease hold-off.
// Optional fast attack on full-scale samples: define CIC_AGC_FAST_ATTACK_EN.
module cic_agc_ctrl #(
  parameter int GAIN_BITS    = 8,
  parameter int GAIN_INIT    = 16,
  parameter int GAIN_MIN     = 0,
  parameter int GAIN_MAX     = 255,
  parameter int WINDOW       = 256,
  parameter int HIGH_THRESH  = 24576,
  parameter int LOW_THRESH   = 8192,
  parameter int STEP_DN      = 4,
  parameter int STEP_UP      = 1,
  parameter int HOLD_WINDOWS = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 enable,
  input  logic [15:0]          x_in,
  input  logic                 in_tick,
  output logic [GAIN_BITS-1:0] gain,
  output logic                 gain_upd,
  output logic [15:0]          peak,
  output logic                 clip
);

  localparam int CW = $clog2(WINDOW);
  localparam int HW = $clog2(HOLD_WINDOWS + 2);
  localparam int GW = GAIN_BITS + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);
  localparam logic [HW-1:0] HOLD_SET = HW'(HOLD_WINDOWS);
  localparam logic [15:0] HI = 16'(HIGH_THRESH);
  localparam logic [15:0] LO = 16'(LOW_THRESH);
  localparam logic [15:0] FULL = 16'h7fff;

  localparam logic [GAIN_BITS-1:0] G_INIT = GAIN_BITS'(GAIN_INIT);
  localparam logic [GAIN_BITS-1:0] G_MIN  = GAIN_BITS'(GAIN_MIN);
  localparam logic [GAIN_BITS-1:0] G_MAX  = GAIN_BITS'(GAIN_MAX);
  localparam logic [GAIN_BITS-1:0] G_DN   = GAIN_BITS'(STEP_DN);
  localparam logic [GAIN_BITS-1:0] G_UP   = GAIN_BITS'(STEP_UP);
  localparam logic [GW-1:0] LIM_DN = GW'(GAIN_MIN + STEP_DN);
  localparam logic [GW-1:0] LIM_UP = GW'(GAIN_MAX - STEP_UP);

  typedef enum logic [1:0] {IDLE, MEASURE, DECIDE, UPDATE} state_t;

  state_t state, state_nx;

  logic [15:0]          mag;
  logic [15:0]          peak_run;
  logic [15:0]          peak_max;
  logic [15:0]          dec_peak;
  logic [CW-1:0]        count;
  logic [HW-1:0]        hold;
  logic                 counting;
  logic                 win_end;
  logic                 fast;
  logic                 dec_hit;
  logic                 inc_hit;
  logic [GAIN_BITS-1:0] gain_nx;

  always_comb begin
    mag = x_in;
    if (x_in[15])
      mag = (x_in == 16'h8000) ? FULL : (~x_in + 16'd1);
  end

  assign peak_max = (mag > peak_run) ? mag : peak_run;
  assign counting = enable && in_tick && (state != IDLE);
  // A short window can end while still in UPDATE; DECIDE never sees it.
  assign win_end  = counting && (count == CNT_LAST) &&
                    (state == MEASURE || state == UPDATE);

`ifdef CIC_AGC_FAST_ATTACK_EN
  assign fast = counting && (state == MEASURE) && !win_end && (mag == FULL);
`else
  assign fast = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nx = MEASURE;
        MEASURE: if (win_end || fast) state_nx = DECIDE;
        DECIDE:  state_nx = UPDATE;
        UPDATE:  state_nx = win_end ? DECIDE : MEASURE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign dec_hit = dec_peak > HI;
  assign inc_hit = !dec_hit && (dec_peak < LO) && (hold == '0);

  always_comb begin
    gain_nx = gain;
    unique case (1'b1)
      dec_hit: gain_nx = ({1'b0, gain} < LIM_DN) ? G_MIN : gain - G_DN;
      inc_hit: gain_nx = ({1'b0, gain} > LIM_UP) ? G_MAX : gain + G_UP;
      default: gain_nx = gain;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      gain     <= G_INIT;
      gain_upd <= 1'b0;
      peak     <= '0;
      clip     <= 1'b0;
      peak_run <= '0;
      dec_peak <= '0;
      count    <= '0;
      hold     <= '0;
    end else begin
      clip     <= in_tick && (mag == FULL);
      gain_upd <= 1'b0;
      if (!enable) begin
        peak_run <= '0;
        count    <= '0;
        hold     <= '0;
      end else begin
        if (win_end) begin
          peak     <= peak_max;
          dec_peak <= peak_max;
          peak_run <= '0;
          count    <= '0;
        end else if (fast) begin
          peak     <= FULL;
          dec_peak <= FULL;
          peak_run <= '0;
          count    <= '0;
        end else if (counting) begin
          peak_run <= peak_max;
          count    <= count + CW'(1);
        end
        if (state == DECIDE) begin
          gain     <= gain_nx;
          gain_upd <= (gain_nx != gain);
          if (dec_hit)          hold <= HOLD_SET;
          else if (hold != '0)  hold <= hold - HW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_agc_ctrl.sv
// Directed bench for cic_agc_ctrl: window table plus corner sequences.
module tb_cic_agc_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] x_in = '0;
  logic        in_tick = 1'b0;
  logic [7:0]  gain;
  logic        gain_upd;
  logic [15:0] peak;
  logic        clip;

  always #5 CLK = ~CLK;

  cic_agc_ctrl dut (
    .CLK(CLK),
    .RST(RST),
    .enable(enable),
    .x_in(x_in),
    .in_tick(in_tick),
    .gain(gain),
    .gain_upd(gain_upd),
    .peak(peak),
    .clip(clip)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] xb;
    logic [15:0] xs;
    int          g;
    int          u;
    int          p;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic tk, input logic [15:0] x);
    @(negedge CLK);
    enable = en;
    in_tick = tk;
    x_in = x;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    enable = 1'b0;
    in_tick = 1'b0;
    x_in = '0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // 256 ticks (one spike at index 77), then checks at T+2 and T+3.
  task automatic run_window(input string nm, input logic [15:0] xb,
                            input logic [15:0] xs, input int eg,
                            input int eu, input int ep);
    for (int i = 0; i < 256; i++)
      cyc(1'b1, 1'b1, (i == 77) ? xs : xb);
    cyc(1'b1, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 16'd0);
    chk({nm, "_gain"}, int'(gain), eg);
    chk({nm, "_upd"}, int'(gain_upd), eu);
    chk({nm, "_peak"}, int'(peak), ep);
    cyc(1'b1, 1'b0, 16'd0);
    chk({nm, "_upd_clr"}, int'(gain_upd), 0);
  endtask

  initial begin
    tbl[0]  = '{16'd30000, 16'd30000, 12, 1, 30000};
    tbl[1]  = '{16'd1000, 16'(-5000), 12, 0, 5000};
    tbl[2]  = '{16'd1000, 16'd1000, 12, 0, 1000};
    tbl[3]  = '{16'd1000, 16'd1000, 12, 0, 1000};
    tbl[4]  = '{16'd1000, 16'd1000, 12, 0, 1000};
    tbl[5]  = '{16'd1000, 16'd1000, 13, 1, 1000};
    tbl[6]  = '{16'd8192, 16'd8192, 13, 0, 8192};
    tbl[7]  = '{16'd100, 16'd24576, 13, 0, 24576};
    tbl[8]  = '{16'd8191, 16'd8191, 14, 1, 8191};
    tbl[9]  = '{16'd24577, 16'd24577, 10, 1, 24577};
    tbl[10] = '{16'h8000, 16'(-100), 6, 1, 32767};

    do_reset();
    chk("rst_gain", int'(gain), 16);
    chk("rst_upd", int'(gain_upd), 0);
    chk("rst_peak", int'(peak), 0);
    chk("rst_clip", int'(clip), 0);

    cyc(1'b1, 1'b0, 16'd0);
    for (int v = 0; v < 11; v++)
      run_window($sformatf("tbl%0d", v), tbl[v].xb, tbl[v].xs,
                 tbl[v].g, tbl[v].u, tbl[v].p);

    // Reset in the middle of a window.
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b1, 16'd30000);
    do_reset();
    chk("midrst_gain", int'(gain), 16);
    chk("midrst_peak", int'(peak), 0);
    chk("midrst_upd", int'(gain_upd), 0);
    cyc(1'b1, 1'b0, 16'd0);
    run_window("low1000", 16'd1000, 16'd1000, 17, 1, 1000);

    // Drive gain down to GAIN_MIN, then a saturated no-op.
    do_reset();
    cyc(1'b1, 1'b0, 16'd0);
    run_window("min1", 16'h8000, 16'h8000, 12, 1, 32767);
    run_window("min2", 16'h8000, 16'h8000, 8, 1, 32767);
    run_window("min3", 16'h7fff, 16'h7fff, 4, 1, 32767);
    run_window("min4", 16'h8000, 16'h8000, 0, 1, 32767);
    run_window("min5", 16'h8000, 16'h8000, 0, 0, 32767);

    cyc(1'b1, 1'b1, 16'h8000);
    cyc(1'b1, 1'b0, 16'd0);
    chk("clip_neg", int'(clip), 1);
    cyc(1'b1, 1'b0, 16'd0);
    chk("clip_clr", int'(clip), 0);
    cyc(1'b0, 1'b1, 16'h7fff);
    cyc(1'b0, 1'b0, 16'h7fff);
    chk("clip_dis", int'(clip), 1);
    cyc(1'b0, 1'b1, 16'h7ffe);
    cyc(1'b0, 1'b0, 16'd0);
    chk("clip_near", int'(clip), 0);

    // enable dropped mid-window; count must restart.
    do_reset();
    cyc(1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, 16'd30000);
    cyc(1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 16'd0);
    chk("en_off_gain", int'(gain), 16);
    chk("en_off_upd", int'(gain_upd), 0);
    cyc(1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 255; i++) cyc(1'b1, 1'b1, 16'd1000);
    cyc(1'b1, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 16'd0);
    chk("en_255_gain", int'(gain), 16);
    cyc(1'b1, 1'b1, 16'd1000);
    cyc(1'b1, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 16'd0);
    chk("en_256_gain", int'(gain), 17);
    chk("en_256_upd", int'(gain_upd), 1);
    chk("en_256_peak", int'(peak), 1000);

    // Ticks on every cycle, including DECIDE and UPDATE.
    do_reset();
    cyc(1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 771; i++) begin
      @(negedge CLK);
      if (i == 257) begin
        chk("cont_w1_gain", int'(gain), 17);
        chk("cont_w1_upd", int'(gain_upd), 1);
      end
      if (i == 258) chk("cont_w1_clr", int'(gain_upd), 0);
      if (i == 513) begin
        chk("cont_w2_peak", int'(peak), 9000);
        chk("cont_w2_gain", int'(gain), 17);
      end
      if (i == 769) begin
        chk("cont_w3_gain", int'(gain), 13);
        chk("cont_w3_peak", int'(peak), 30000);
      end
      enable = 1'b1;
      in_tick = 1'b1;
      if (i < 511)       x_in = 16'd1000;
      else if (i == 511) x_in = 16'd9000;
      else               x_in = 16'd30000;
    end
    cyc(1'b1, 1'b0, 16'd0);

    // Full-scale sample at index 10 of a window.
    do_reset();
    cyc(1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 256; i++) begin
      @(negedge CLK);
`ifdef CIC_AGC_FAST_ATTACK_EN
      if (i == 12) chk("fa_early_gain", int'(gain), 12);
`else
      if (i == 12) chk("fa_early_gain", int'(gain), 16);
`endif
      enable = 1'b1;
      in_tick = 1'b1;
      x_in = (i == 10) ? 16'h7fff : 16'd1000;
    end
    cyc(1'b1, 1'b0, 16'd0);
    cyc(1'b1, 1'b0, 16'd0);
    chk("fa_end_gain", int'(gain), 12);
    chk("fa_end_peak", int'(peak), 32767);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
